// File: rtl/barrelshifter32_selftest.sv
// Self-test engine for the 32-bit barrel shifter. It sweeps 256 a/b/aluc vectors, predicts c with a
// bit-serial shift model, and counts mismatches. Optional macro: SELFTEST_STOP_ON_FAIL_EN (halt on first mismatch).
module barrelshifter32_selftest #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [31:0] PATTERN0      = 32'hFFFF_FFFF,
  parameter logic [31:0] PATTERN1      = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [31:0] dut_a,
  output logic [4:0]  dut_b,
  output logic [1:0]  dut_aluc,
  input  logic [31:0] dut_c,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [8:0]  err_count,
  output logic [7:0]  vec_index
);

  localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    SETTLE,
    CHECK,
    DONE
  } state_t;

  state_t      state;
  logic [31:0] exp_val;
  logic [4:0]  shift_cnt;
  logic [15:0] settle_cnt;
  logic        mismatch;

  // vec_index is the loop counter: [7] pattern, [6:5] aluc slot, [4:0] shift amount.
  function automatic logic [1:0] slot_aluc(input logic [1:0] slot);
    case (slot)
      2'd0:    return 2'b11;
      2'd1:    return 2'b01;
      2'd2:    return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic [31:0] shift_one(input logic [31:0] v, input logic [1:0] mode);
    case (mode)
      2'b00:   return {v[31], v[31:1]};
      2'b01:   return {1'b0, v[31:1]};
      default: return {v[30:0], 1'b0};
    endcase
  endfunction

  assign mismatch = (dut_c != exp_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      dut_a      <= '0;
      dut_b      <= '0;
      dut_aluc   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      vec_index  <= '0;
      exp_val    <= '0;
      shift_cnt  <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD;
            busy      <= 1'b1;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            vec_index <= '0;
          end
        end

        LOAD: begin
          dut_a     <= vec_index[7] ? PATTERN1 : PATTERN0;
          dut_b     <= vec_index[4:0];
          dut_aluc  <= slot_aluc(vec_index[6:5]);
          exp_val   <= vec_index[7] ? PATTERN1 : PATTERN0;
          shift_cnt <= vec_index[4:0];
          state     <= SHIFT;
        end

        SHIFT: begin
          if (shift_cnt != 5'd0) begin
            exp_val   <= shift_one(exp_val, dut_aluc);
            shift_cnt <= shift_cnt - 5'd1;
          end else begin
            settle_cnt <= SETTLE_LAST;
            state      <= SETTLE;
          end
        end

        SETTLE: begin
          if (settle_cnt == 16'd0) state <= CHECK;
          else                     settle_cnt <= settle_cnt - 16'd1;
        end

        CHECK: begin
`ifdef SELFTEST_STOP_ON_FAIL_EN
          // Freeze vec_index and dut_* on the failing vector.
          if (mismatch) begin
            err_count <= err_count + 9'd1;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
            pass      <= 1'b0;
          end else if (vec_index == 8'd255) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 9'd0);
          end else begin
            vec_index <= vec_index + 8'd1;
            state     <= LOAD;
          end
`else
          err_count <= err_count + 9'(mismatch);
          if (vec_index == 8'd255) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == 9'd0) && !mismatch;
          end else begin
            vec_index <= vec_index + 8'd1;
            state     <= LOAD;
          end
`endif
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_barrelshifter32_selftest.sv
// Bench for barrelshifter32_selftest: a behavioural shifter with injectable faults feeds dut_c, and a
// vector-level model predicts error count, first failing vector and sweep length.
module tb_barrelshifter32_selftest;

  localparam logic [31:0] P0 = 32'hFFFF_FFFF;
  localparam logic [31:0] P1 = 32'h8000_0000;
  localparam int          S  = 1;
  localparam int          LIMIT = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] dut_a;
  logic [4:0]  dut_b;
  logic [1:0]  dut_aluc;
  logic [31:0] dut_c;
  logic        busy;
  logic        done;
  logic        pass;
  logic [8:0]  err_count;
  logic [7:0]  vec_index;

  int          total = 0;
  int          bad   = 0;
  int          fault_mode = 0;
  logic [31:0] flip_mask [256];

  barrelshifter32_selftest #(.SETTLE_CYCLES(S), .PATTERN0(P0), .PATTERN1(P1)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dut_a(dut_a), .dut_b(dut_b), .dut_aluc(dut_aluc), .dut_c(dut_c),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count), .vec_index(vec_index)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_shift(logic [31:0] a, int b, logic [1:0] aluc);
    logic [31:0] r;
    if (aluc == 2'b00)      r = $signed(a) >>> b;
    else if (aluc == 2'b01) r = a >> b;
    else                    r = a << b;
    return r;
  endfunction

  function automatic logic [1:0] aluc_of_slot(int slot);
    logic [1:0] tbl [4];
    tbl = '{2'b11, 2'b01, 2'b10, 2'b00};
    return tbl[slot];
  endfunction

  function automatic int vec_of(logic [31:0] a, logic [4:0] b, logic [1:0] aluc);
    int slot;
    case (aluc)
      2'b11:   slot = 0;
      2'b01:   slot = 1;
      2'b10:   slot = 2;
      default: slot = 3;
    endcase
    return ((a == P1) ? 128 : 0) + slot * 32 + int'(b);
  endfunction

  function automatic logic [31:0] faulty(logic [31:0] a, int b, logic [1:0] aluc, int mode, logic [31:0] flip);
    logic [31:0] r;
    r = ref_shift(a, b, aluc);
    case (mode)
      1: r = r | 32'd1;
      2: if (aluc == 2'b00) r = a >> b;
      3: r = r ^ flip;
      default: ;
    endcase
    return r;
  endfunction

  assign dut_c = faulty(dut_a, int'(dut_b), dut_aluc, fault_mode, flip_mask[vec_of(dut_a, dut_b, dut_aluc)]);

  // Predicts what a sweep should report given the current fault configuration.
  task automatic model(output int nerr, output int first, output int cyc_full, output int cyc_first);
    logic [31:0] a, good, got;
    int b;
    nerr = 0; first = -1; cyc_full = 0; cyc_first = 0;
    for (int v = 0; v < 256; v++) begin
      a = (v < 128) ? P0 : P1;
      b = v % 32;
      good = ref_shift(a, b, aluc_of_slot((v / 32) % 4));
      got  = faulty(a, b, aluc_of_slot((v / 32) % 4), fault_mode, flip_mask[v]);
      cyc_full += b + 3 + S;
      if (first < 0) cyc_first += b + 3 + S;
      if (got != good) begin
        nerr++;
        if (first < 0) first = v;
      end
    end
  endtask

  task automatic sweep(output int cyc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
    end
    total++;
    if (done !== 1'b1) begin
      bad++;
      $display("FAIL sweep_timeout: done=%b after %0d cycles, required done=1", done, cyc);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({dut_a, dut_b, dut_aluc, busy, done, pass, err_count, vec_index} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: a=%h b=%0d aluc=%b busy=%b done=%b pass=%b err=%0d vec=%0d, required all 0",
               dut_a, dut_b, dut_aluc, busy, done, pass, err_count, vec_index);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({busy, done} !== 2'b00) begin
      bad++;
      $display("FAIL idle_without_start: busy=%b done=%b, required 0 0", busy, done);
    end
  endtask

  // Full sweep against the model; literal expectations checked separately by callers.
  task automatic run_fault(string name, int mode);
    int nerr, first, cf, c1, cyc, ev, exp_cyc;
    logic exp_pass;
    fault_mode = mode;
    model(nerr, first, cf, c1);
`ifdef SELFTEST_STOP_ON_FAIL_EN
    ev      = (first >= 0) ? first : 255;
    exp_cyc = (first >= 0) ? c1 : cf;
    nerr    = (first >= 0) ? 1 : 0;
`else
    ev      = 255;
    exp_cyc = cf;
`endif
    exp_pass = (nerr == 0);
    sweep(cyc);
    total++;
    if (cyc != exp_cyc) begin
      bad++; $display("FAIL %s_cycles: got %0d, required %0d", name, cyc, exp_cyc);
    end
    total++;
    if (err_count !== 9'(nerr) || pass !== exp_pass || busy !== 1'b0) begin
      bad++; $display("FAIL %s_result: err=%0d pass=%b busy=%b, required err=%0d pass=%b busy=0",
                      name, err_count, pass, busy, nerr, exp_pass);
    end
    total++;
    if (vec_index !== 8'(ev) || dut_a !== ((ev < 128) ? P0 : P1) || dut_b !== 5'(ev % 32)
        || dut_aluc !== aluc_of_slot((ev / 32) % 4)) begin
      bad++; $display("FAIL %s_final_vector: vec=%0d a=%h b=%0d aluc=%b, required vec=%0d",
                      name, vec_index, dut_a, dut_b, dut_aluc, ev);
    end
  endtask

  task automatic test_nominal;
    run_fault("nominal", 0);
    total++;
    if (err_count !== 9'd0 || pass !== 1'b1 || vec_index !== 8'd255) begin
      bad++; $display("FAIL nominal_literal: err=%0d pass=%b vec=%0d, required 0 1 255", err_count, pass, vec_index);
    end
    repeat (20) @(negedge clk);
    total++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      bad++; $display("FAIL done_held: done=%b pass=%b, required 1 1", done, pass);
    end
  endtask

  task automatic test_stuck_c0;
    run_fault("stuck_c0", 1);
    total++;
`ifdef SELFTEST_STOP_ON_FAIL_EN
    if (vec_index !== 8'd1 || err_count !== 9'd1 || dut_b !== 5'd1 || dut_aluc !== 2'b11 || dut_a !== P0) begin
      bad++; $display("FAIL stuck_c0_stop: vec=%0d err=%0d b=%0d aluc=%b a=%h, required 1 1 1 11 ffffffff",
                      vec_index, err_count, dut_b, dut_aluc, dut_a);
    end
`else
    if (err_count !== 9'd188 || pass !== 1'b0) begin
      bad++; $display("FAIL stuck_c0_count: err=%0d pass=%b, required 188 0", err_count, pass);
    end
`endif
  endtask

  task automatic test_arith_as_logical;
    run_fault("arith_as_logical", 2);
`ifndef SELFTEST_STOP_ON_FAIL_EN
    total++;
    if (err_count !== 9'd62) begin
      bad++; $display("FAIL arith_as_logical_count: err=%0d, required 62", err_count);
    end
`endif
  endtask

  task automatic test_random_faults;
    for (int it = 0; it < 3; it++) begin
      for (int v = 0; v < 256; v++)
        flip_mask[v] = ($urandom_range(15) == 0) ? (32'd1 << $urandom_range(31)) : 32'd0;
      run_fault($sformatf("random%0d", it), 3);
    end
    for (int v = 0; v < 256; v++) flip_mask[v] = 32'd0;
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (vec_index !== 8'd50 && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (vec_index !== 8'd50) begin
      bad++; $display("FAIL reach_vec50: vec=%0d, required 50", vec_index);
    end
    repeat ($urandom_range(3)) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if ({dut_a, dut_b, dut_aluc, busy, done, pass, err_count, vec_index} !== '0) begin
      bad++; $display("FAIL reset_mid_sweep: busy=%b done=%b err=%0d vec=%0d a=%h, required all 0",
                      busy, done, err_count, vec_index, dut_a);
    end
    run_fault("after_reset", 0);
  endtask

  task automatic test_back_to_back;
    int cyc;
    fault_mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++; $display("FAIL restart_from_done: busy=%b done=%b, required 1 0", busy, done);
    end
    cyc = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      start = (busy === 1'b1) && ($urandom_range(7) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    total++;
    if (cyc != 4992 || pass !== 1'b1 || err_count !== 9'd0) begin
      bad++; $display("FAIL back_to_back: cycles=%0d pass=%b err=%0d, required 4992 1 0", cyc, pass, err_count);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    for (int v = 0; v < 256; v++) flip_mask[v] = 32'd0;
    test_reset();
    test_nominal();
    test_stuck_c0();
    test_arith_as_logical();
    test_random_faults();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
